// File: rtl/vga_vram_fetch.sv
// vga_vram_fetch
//   Display-side fetch engine. Walks the frame buffer linearly from word 0,
//   keeping one read outstanding at a time on the vram_vga_* handshake, and
//   buffers returned words in a small first-word-fall-through FIFO that the
//   pixel serializer drains one 32-bit word at a time.
//
//   State table:
//     IDLE  (0) | no request outstanding; issue next read when FIFO has room
//     REQ   (1) | request outstanding; push returned word on ready
//     DRAIN (2) | request abandoned by frame_start; discard data on ready
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   frame_start         flush FIFO, restart fetch at address 0
//   word_rd             pop strobe from the pixel serializer
//   word_out            FIFO head word (valid while word_avail=1)
//   word_avail          FIFO non-empty
//   fifo_level          FIFO occupancy
//   underflow           sticky pop-on-empty flag, cleared by frame_start
//   frame_done          whole frame fetched
//   vram_vga_addr/req   read request to the RAM controller
//   vram_vga_data_in    read data, valid with vram_vga_ready
//   vram_vga_ready      read acknowledge / data-valid strobe
//   state_out           FSM state, for debug
module vga_vram_fetch #(
   parameter int FRAME_WORDS = 21504,
   parameter int FIFO_DEPTH  = 8,
   parameter int FIFO_AW     = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               frame_start,
   input  logic               word_rd,
   output logic [31:0]        word_out,
   output logic               word_avail,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               underflow,
   output logic               frame_done,
   output logic [14:0]        vram_vga_addr,
   output logic               vram_vga_req,
   input  logic [31:0]        vram_vga_data_in,
   input  logic               vram_vga_ready,
   output logic [1:0]         state_out
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [14:0]      LAST_ADDR = 15'(FRAME_WORDS - 1);
   localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(FIFO_DEPTH);

   state_t               state_q;
   logic [14:0]          ptr_q;
   logic [14:0]          addr_q;
   logic                 req_q;
   logic                 frame_done_q;
   logic                 underflow_q;

   logic [31:0]          mem_q [FIFO_DEPTH];
   logic [FIFO_AW-1:0]   rd_q;
   logic [FIFO_AW-1:0]   wr_q;
   logic [FIFO_AW:0]     count_q;

   logic                 push;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;

   assign fifo_full  = (count_q == DEPTH_C);
   assign fifo_empty = (count_q == '0);

   // frame_start takes priority: a word returning in the same cycle is
   // discarded and a simultaneous pop is ignored.
   assign push = (state_q == ST_REQ) && vram_vga_ready && !frame_start;
   assign pop  = word_rd && !fifo_empty && !frame_start;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         addr_q       <= '0;
         req_q        <= 1'b0;
         frame_done_q <= 1'b1;
         underflow_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // No issue on the frame_start cycle itself: the pointer is
               // being reset, so the first request follows one cycle later.
               if (!frame_start && !frame_done_q && !fifo_full) begin
                  state_q <= ST_REQ;
                  req_q   <= 1'b1;
                  addr_q  <= ptr_q;
               end
            end
            ST_REQ: begin
               if (vram_vga_ready) begin
                  state_q <= ST_IDLE;
                  req_q   <= 1'b0;
                  if (!frame_start) begin
                     if (ptr_q == LAST_ADDR) begin
                        frame_done_q <= 1'b1;
                     end else begin
                        ptr_q <= ptr_q + 15'd1;
                     end
                  end
               end else if (frame_start) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // addr/req stay put until the abandoned read completes.
               if (vram_vga_ready) begin
                  state_q <= ST_IDLE;
                  req_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               req_q   <= 1'b0;
            end
         endcase

         if (frame_start) begin
            ptr_q        <= '0;
            frame_done_q <= 1'b0;
         end

         if (frame_start) begin
            underflow_q <= 1'b0;
         end else if (word_rd && fifo_empty) begin
            underflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else if (frame_start) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= vram_vga_data_in;
            wr_q        <= wr_q + FIFO_AW'(1);
         end
         if (pop) begin
            rd_q <= rd_q + FIFO_AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign word_out      = mem_q[rd_q];
   assign word_avail    = !fifo_empty;
   assign fifo_level    = count_q;
   assign underflow     = underflow_q;
   assign frame_done    = frame_done_q;
   assign vram_vga_addr = addr_q;
   assign vram_vga_req  = req_q;
   assign state_out     = state_q;

endmodule
